uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter of the debug unit among up to N_REQ byte-stream requesters: the pipe-dump sender, the command-acknowledge reporter and the error/status reporter. Ownership passes round-robin and is frame-atomic. A requester keeps the transmitter from its first byte through the byte it marks last. The block sits between the debug FSMs and the UART TX core, replacing direct `os_tx_start`/`o_tx_data` wiring.

## Interface
- N_REQ, 3: number of requesters (2..8).
- DATA_W, 8: byte width of UART data.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  requester i has a byte valid on its lane; held until acked.
- i_data  in  N_REQ*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- i_last  in  N_REQ  the byte on lane i is the final byte of its frame.
- o_ack  out  N_REQ  one-cycle pulse: the byte on lane i was taken.
- o_grant  out  N_REQ  one-hot owner of the transmitter; 0 when free.
- o_tx_data  out  DATA_W  byte to the UART TX core.
- os_tx_start  out  1  one-cycle start pulse to the UART TX core.
- is_tx_done  in  1  one-cycle pulse from the UART TX core when its byte is finished.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no owner.
  - LOAD: owner selected, waiting for its byte.
  - WAIT: byte in flight.
- IDLE:
  - If any `i_req` is high, select a winner. The search starts at index ptr+1 mod N_REQ and takes the first requester with `i_req` high.
  - Register the one-hot winner in `o_grant` and go to LOAD.
  - If no `i_req` is high, stay in IDLE.
- LOAD:
  - If `i_req[owner]` is high: register `o_tx_data`←lane data, pulse `os_tx_start` and `o_ack[owner]`, latch `i_last[owner]` into last_r, and go to WAIT.
  - If `i_req[owner]` is low, stay in LOAD with the grant held. There is no preemption mid-frame.
- WAIT:
  - On `is_tx_done` with last_r=1: ptr←owner, `o_grant`←0, go to IDLE.
  - On `is_tx_done` with last_r=0: go to LOAD and keep the grant.
  - `is_tx_done` seen outside WAIT is ignored.
- Fairness: a requester that just finished a frame has the lowest priority in the next arbitration. Any continuously requesting lane wins within N_REQ frames.
- Single-byte frame (`i_last` set on the first byte): the grant is released after that one byte.
- A requester may only change `i_data`/`i_last` after its `o_ack`. The arbiter samples them only in the LOAD cycle.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, ptr=N_REQ-1 so lane 0 wins first.
  - `o_grant`=0, `o_ack`=0, `os_tx_start`=0, `o_tx_data`=0, `o_busy`=0, last_r=0.
- Reset mid-frame: the frame is abandoned and no ack is produced. The UART core is reset by the same rst.
- All outputs are registered.
- Latency:
  - `i_req` rises in IDLE at cycle N, so `o_grant` is valid at N+1 (LOAD).
  - `os_tx_start`, `o_ack` and `o_tx_data` are valid at N+2.
  - After `is_tx_done` at cycle M with last_r=0, the next `os_tx_start` is at M+2 if the owner's `i_req` is high.
- `os_tx_start` and `o_ack` are exactly one cycle wide and always coincide. At most one `o_ack` bit is high at a time.
- `is_tx_done` in the same cycle as a new `i_req` on another lane: the release is taken first. Arbitration for the new request happens in the following IDLE cycle.
- `o_tx_data` holds its value until the next start.

## Structure
- Shared debug package:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2)
  - N_REQ default
  - requester index constants: REQ_SEND=0, REQ_ACK=1, REQ_ERR=2.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are req vector and ptr; outputs are one-hot grant and the encoded index.
- The FSM, data mux and registers stay in the top module.

## Test plan
- Reset values: hold rst=0 with random inputs → all outputs 0; after release, `o_busy`=0.
- Single lane: lane 0 sends a 3-byte frame 0xA1, 0xA2, 0xA3 (last on 0xA3), and a model UART returns done 10 cycles after each start → three starts carrying 0xA1, 0xA2, 0xA3; `o_grant`=001 throughout; release to 000 one cycle after the third done.
- Contention: lanes 0, 1 and 2 request one-byte frames simultaneously and keep re-requesting → grant order 0,1,2,0,1,2; no lane starves.
- Frame atomicity: lane 1 owns the transmitter with a 4-byte frame while lane 0 requests mid-frame → all 4 lane-1 bytes go first, then lane 0; no interleaving.
- Owner stall: after byte 1, the owner drops `i_req` for 20 cycles → state stays LOAD and no start is issued; the grant is kept; the next byte is sent 1 cycle after `i_req` returns.
- Reset mid-frame: rst pulled low in WAIT → immediate return to reset values; after release, lane 0 wins the next arbitration.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared debug-unit definitions for the UART transmitter arbiter: FSM states,
// requester lane indices and the index-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  localparam int unsigned N_REQ_DEF = 3;

  localparam int unsigned REQ_SEND = 0;
  localparam int unsigned REQ_ACK  = 1;
  localparam int unsigned REQ_ERR  = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts one past ptr and
// returns the first active requester as one-hot grant plus encoded index.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N  = N_REQ_DEF,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UART transmitter among
// N_REQ byte-stream requesters; all outputs are registered.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  input  logic [N_REQ-1:0]        i_last,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_grant,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    os_tx_start,
  input  logic                    is_tx_done,
  output logic                    o_busy
);

  localparam int unsigned IW = idx_w(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              last_q, last_d;
  logic [N_REQ-1:0]  grant_d, ack_d;
  logic [DATA_W-1:0] data_d;
  logic              start_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              own_req, own_last;
  logic [DATA_W-1:0] own_data;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Owner lane view, only consulted in LOAD
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_req  = i_req[i];
        own_last = i_last[i];
        own_data = i_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = o_grant;
    data_d  = o_tx_data;
    ack_d   = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (own_req) begin
          data_d  = own_data;
          start_d = 1'b1;
          ack_d   = o_grant;
          last_d  = own_last;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (is_tx_done) begin
          if (last_q) begin
            ptr_d   = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(N_REQ - 1);
      owner_q     <= '0;
      last_q      <= 1'b0;
      o_grant     <= '0;
      o_ack       <= '0;
      os_tx_start <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      o_grant     <= grant_d;
      o_ack       <= ack_d;
      os_tx_start <= start_d;
      o_tx_data   <= data_d;
      o_busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-lane frame queues, a model UART
// and a rule-based expectation of grants, starts and data.
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        i_last;
  logic [N_REQ-1:0]        o_ack;
  logic [N_REQ-1:0]        o_grant;
  logic [DATA_W-1:0]       o_tx_data;
  logic                    os_tx_start;
  logic                    is_tx_done;
  logic                    o_busy;

  uart_tx_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_ack       (o_ack),
    .o_grant     (o_grant),
    .o_tx_data   (o_tx_data),
    .os_tx_start (os_tx_start),
    .is_tx_done  (is_tx_done),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W:0]   fifo [N_REQ][DEPTH];
  int                wr [N_REQ];
  int                rd [N_REQ];
  int                stall [N_REQ];
  int                stall_after [N_REQ];
  int                uart_cnt, uart_delay;
  bit                rand_mode;
  logic [N_REQ-1:0]  prev_grant, grant_or;
  logic              wait_prev, byte_last;
  logic [DATA_W-1:0] prev_data;
  int                last_owner, cyc, pushed, started;
  int                win_log [$];
  int                tx_lane [$];
  int                tx_cyc [$];
  logic [DATA_W-1:0] tx_log [$];
  int                checks, failures;

  logic [DATA_W-1:0] exp_single [3] = '{8'hA1, 8'hA2, 8'hA3};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] rr_expect(input logic [N_REQ-1:0] req, input int last);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (r == '0 && req[(last + k) % N_REQ]) r[(last + k) % N_REQ] = 1'b1;
    end
    return r;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic bench_idle();
    logic e;
    e = (o_grant == '0) && !wait_prev && (uart_cnt == 0);
    for (int i = 0; i < N_REQ; i++) if (rd[i] != wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      if (rd[i] != wr[i]) begin
        i_req[i]                    = (stall[i] == 0);
        i_data[i*DATA_W +: DATA_W]  = fifo[i][rd[i] % DEPTH][DATA_W-1:0];
        i_last[i]                   = fifo[i][rd[i] % DEPTH][DATA_W];
      end else begin
        i_req[i]                    = 1'b0;
        i_data[i*DATA_W +: DATA_W]  = DATA_W'($urandom);
        i_last[i]                   = 1'($urandom);
      end
    end
  endtask

  task automatic push(input int lane, input logic [DATA_W-1:0] d, input logic last);
    fifo[lane][wr[lane] % DEPTH] = {last, d};
    wr[lane]++;
    pushed++;
    drive_inputs();
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_REQ; i++) begin
      wr[i] = 0; rd[i] = 0; stall[i] = 0; stall_after[i] = 0;
    end
    uart_cnt   = 0;
    prev_grant = '0;
    wait_prev  = 1'b0;
    byte_last  = 1'b0;
    prev_data  = '0;
    last_owner = N_REQ - 1;
  endtask

  task automatic clear_logs();
    win_log.delete(); tx_lane.delete(); tx_cyc.delete(); tx_log.delete();
    grant_or = '0;
  endtask

  task automatic observe();
    logic [N_REQ-1:0] g;
    logic             exp_start, wait_now, fire, pending;
    int               own, len;
    g = o_grant;
    cyc++;
    grant_or |= g;
    check("busy", 32'(o_busy), 32'(|g));
    check("ack_with_start", 32'(o_ack), os_tx_start ? 32'(g) : 32'd0);
    check("grant_onehot", 32'($countones(g) <= 1), 32'd1);

    if (prev_grant == '0) begin
      check("grant_arb", 32'(g), 32'(rr_expect(i_req, last_owner)));
      if (g != '0) win_log.push_back(onehot_idx(g));
    end else if (wait_prev && is_tx_done && byte_last) begin
      check("grant_release", 32'(g), 32'd0);
      last_owner = onehot_idx(prev_grant);
    end else begin
      check("grant_hold", 32'(g), 32'(prev_grant));
    end

    exp_start = (prev_grant != '0) && !wait_prev && ((i_req & prev_grant) != '0);
    check("tx_start", 32'(os_tx_start), 32'(exp_start));
    wait_now = os_tx_start || (wait_prev && !is_tx_done);

    for (int i = 0; i < N_REQ; i++) if (stall[i] > 0) stall[i]--;

    if (os_tx_start && g != '0) begin
      own     = onehot_idx(g);
      pending = (rd[own] != wr[own]);
      check("tx_lane_pending", 32'(pending), 32'd1);
      if (pending) begin
        check("tx_data", 32'(o_tx_data), 32'(fifo[own][rd[own] % DEPTH][DATA_W-1:0]));
        byte_last = fifo[own][rd[own] % DEPTH][DATA_W];
        rd[own]++;
        started++;
        tx_log.push_back(o_tx_data);
        tx_lane.push_back(own);
        tx_cyc.push_back(cyc);
        if (rand_mode && $urandom_range(0, 7) == 0) stall[own] = int'($urandom_range(1, 6));
        else stall[own] = stall_after[own];
        stall_after[own] = 0;
      end
    end else if (!os_tx_start) begin
      check("tx_data_hold", 32'(o_tx_data), 32'(prev_data));
    end

    fire = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      fire = (uart_cnt == 0);
    end
    if (os_tx_start) uart_cnt = rand_mode ? int'($urandom_range(2, 12)) : uart_delay;
    // Spurious done pulses only where the transmitter is not in flight
    if (rand_mode && !fire && uart_cnt == 0 && !wait_now && $urandom_range(0, 15) == 0) fire = 1'b1;

    if (rand_mode) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rd[i] == wr[i] && $urandom_range(0, 5) == 0) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) begin
            fifo[i][wr[i] % DEPTH] = {(b == len - 1), DATA_W'($urandom)};
            wr[i]++;
            pushed++;
          end
        end
      end
    end

    is_tx_done = fire;
    drive_inputs();
    prev_grant = g;
    wait_prev  = wait_now;
    prev_data  = o_tx_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bench_idle() && n < budget);
    check("drain", 32'(bench_idle()), 32'd1);
  endtask

  task automatic wait_starts(input int cnt, input int budget);
    int n;
    n = 0;
    while (tx_log.size() < cnt && n < budget) begin
      step();
      n++;
    end
    check("start_timeout", 32'(tx_log.size() >= cnt), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_start", 32'(os_tx_start), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic randomize_inputs();
    i_req      = N_REQ'($urandom);
    i_last     = N_REQ'($urandom);
    i_data     = (N_REQ*DATA_W)'($urandom);
    is_tx_done = 1'($urandom);
  endtask

  task automatic do_reset(input int hold);
    #2;
    rst = 1'b0;
    randomize_inputs();
    #1;
    check_reset_outputs();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_reset_outputs();
      randomize_inputs();
    end
    model_clear();
    is_tx_done = 1'b0;
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    i_req      = '0;
    i_data     = '0;
    i_last     = '0;
    is_tx_done = 1'b0;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    pushed     = 0;
    started    = 0;
    rand_mode  = 0;
    uart_delay = 10;
    model_clear();
    clear_logs();

    do_reset(4);
    step();
    check("busy_after_reset", 32'(o_busy), 32'd0);

    // Single lane, three-byte frame
    clear_logs();
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b0);
    push(0, 8'hA3, 1'b1);
    run_idle(300);
    check("single_count", tx_log.size(), 3);
    for (int k = 0; k < 3 && k < tx_log.size(); k++) check("single_byte", 32'(tx_log[k]), 32'(exp_single[k]));
    check("single_grant", 32'(grant_or), 32'd1);

    // Contention with continuous re-requests
    do_reset(2);
    clear_logs();
    uart_delay = 3;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_REQ; i++) push(i, DATA_W'(16 * i + r + 1), 1'b1);
    run_idle(300);
    check("contend_count", win_log.size(), 6);
    for (int k = 0; k < 6 && k < win_log.size(); k++) check("contend_order", win_log[k], k % N_REQ);

    // Frame atomicity
    clear_logs();
    for (int b = 0; b < 4; b++) push(1, DATA_W'(8'hB0 + b), (b == 3));
    wait_starts(1, 100);
    push(0, 8'hC0, 1'b1);
    run_idle(300);
    check("atomic_count", tx_lane.size(), 5);
    for (int k = 0; k < 5 && k < tx_lane.size(); k++) begin
      check("atomic_lane", tx_lane[k], (k < 4) ? 1 : 0);
      check("atomic_byte", 32'(tx_log[k]), (k < 4) ? 32'(8'hB0 + k) : 32'h00C0);
    end

    // Owner stall between bytes
    clear_logs();
    uart_delay     = 10;
    stall_after[2] = 20;
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b0);
    push(2, 8'h73, 1'b1);
    run_idle(300);
    check("stall_count", tx_cyc.size(), 3);
    if (tx_cyc.size() >= 2) check("stall_gap", tx_cyc[1] - tx_cyc[0], 21);

    // Reset mid-frame: pointer must return to its reset position
    clear_logs();
    push(0, 8'h55, 1'b1);
    run_idle(100);
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    wait_starts(2, 100);
    step();
    step();
    do_reset(3);
    clear_logs();
    for (int i = 0; i < N_REQ; i++) push(i, DATA_W'(8'hD0 + i), 1'b1);
    run_idle(300);
    check("rst_mid_first", (win_log.size() > 0) ? win_log[0] : -1, 0);

    // Randomized traffic
    clear_logs();
    pushed    = 0;
    started   = 0;
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    run_idle(2000);
    check("rand_all_sent", started, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
